// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address-width helper and address type for regfile_mp
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO = 0;
  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/reserve port bundle between decode (master) and regfile_mp (slave)
interface regfile_mp_if #(
  parameter int XLEN = regfile_pkg::XLEN_DEF,
  parameter int NREGS = regfile_pkg::NREGS_DEF
);
  localparam int AW = regfile_pkg::aw_of(NREGS);
  logic [AW-1:0] readReg1, readReg2, writeReg0, writeReg1, resvReg;
  logic [XLEN-1:0] readData1, readData2, writeData0, writeData1;
  logic readPending1, readPending2, regWrite0, regWrite1, resvValid, resvConflict;
  modport master (
    output readReg1, readReg2, regWrite0, regWrite1, writeReg0, writeReg1,
           writeData0, writeData1, resvValid, resvReg,
    input  readData1, readData2, readPending1, readPending2, resvConflict
  );
  modport slave (
    input  readReg1, readReg2, regWrite0, regWrite1, writeReg0, writeReg1,
           writeData0, writeData1, resvValid, resvReg,
    output readData1, readData2, readPending1, readPending2, resvConflict
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with reserve-over-release priority; REGFILE_BYPASS_EN adds same-cycle release visibility
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          resv_valid,
  input  logic [AW-1:0] resv_reg,
  input  logic          clr0,
  input  logic [AW-1:0] clr0_reg,
  input  logic          clr1,
  input  logic [AW-1:0] clr1_reg,
  input  logic [AW-1:0] rd_reg1,
  input  logic [AW-1:0] rd_reg2,
  output logic          pend1,
  output logic          pend2,
  output logic          resv_conflict
);
  logic [NREGS-1:0] pending, pending_nx;
  logic resv_set;
  assign resv_set = resv_valid && resv_reg != AW'(REG_ZERO);
  // Reserve is applied last so it overrides a same-cycle release
  always_comb begin
    pending_nx = pending;
    if (clr0) pending_nx[clr0_reg] = 1'b0;
    if (clr1) pending_nx[clr1_reg] = 1'b0;
    if (resv_set) pending_nx[resv_reg] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      resv_conflict <= 1'b0;
    end else begin
      pending <= pending_nx;
      resv_conflict <= resv_set && pending[resv_reg];
    end
  end
`ifdef REGFILE_BYPASS_EN
  // Stored bit still set after this edge's releases and reserves
  assign pend1 = !reset && pending[rd_reg1] && pending_nx[rd_reg1];
  assign pend2 = !reset && pending[rd_reg2] && pending_nx[rd_reg2];
`else
  assign pend1 = !reset && pending[rd_reg1];
  assign pend2 = !reset && pending[rd_reg2];
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with r0 hardwired to zero and a pending scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input logic clk,
  input logic reset,
  regfile_mp_if.slave bus
);
  localparam int AW = aw_of(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  logic we0, we1;
  logic [AW-1:0] ra1, ra2;
  assign ra1 = bus.readReg1;
  assign ra2 = bus.readReg2;
  // Port 0 is dropped when port 1 targets the same register
  assign we1 = bus.regWrite1 && bus.writeReg1 != AW'(REG_ZERO);
  assign we0 = bus.regWrite0 && bus.writeReg0 != AW'(REG_ZERO) && !(we1 && bus.writeReg1 == bus.writeReg0);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[bus.writeReg0] <= bus.writeData0;
      if (we1) regs[bus.writeReg1] <= bus.writeData1;
    end
  end
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    bus.readData1 = (reset || ra1 == AW'(REG_ZERO)) ? '0 :
                    (we1 && bus.writeReg1 == ra1) ? bus.writeData1 :
                    (we0 && bus.writeReg0 == ra1) ? bus.writeData0 : regs[ra1];
    bus.readData2 = (reset || ra2 == AW'(REG_ZERO)) ? '0 :
                    (we1 && bus.writeReg1 == ra2) ? bus.writeData1 :
                    (we0 && bus.writeReg0 == ra2) ? bus.writeData0 : regs[ra2];
  end
`else
  always_comb begin
    bus.readData1 = (reset || ra1 == AW'(REG_ZERO)) ? '0 : regs[ra1];
    bus.readData2 = (reset || ra2 == AW'(REG_ZERO)) ? '0 : regs[ra2];
  end
`endif
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .reset(reset),
    .resv_valid(bus.resvValid),
    .resv_reg(bus.resvReg),
    .clr0(we0),
    .clr0_reg(bus.writeReg0),
    .clr1(we1),
    .clr1_reg(bus.writeReg1),
    .rd_reg1(ra1),
    .rd_reg2(ra2),
    .pend1(bus.readPending1),
    .pend2(bus.readPending2),
    .resv_conflict(bus.resvConflict)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array model; honours REGFILE_BYPASS_EN
module tb_regfile_mp;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  regfile_mp_if #(.XLEN(32), .NREGS(32)) bus ();
  regfile_mp #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_regs [32];
  bit m_pend [32];
  bit m_conf;

  task automatic idle();
    bus.regWrite0 = 1'b0;
    bus.regWrite1 = 1'b0;
    bus.writeReg0 = '0;
    bus.writeReg1 = '0;
    bus.writeData0 = '0;
    bus.writeData1 = '0;
    bus.resvValid = 1'b0;
    bus.resvReg = '0;
  endtask

  function automatic logic [31:0] exp_data(input reg_addr_t a);
    if (reset || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.regWrite1 && bus.writeReg1 == a) return bus.writeData1;
    if (bus.regWrite0 && bus.writeReg0 == a) return bus.writeData0;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_pend(input reg_addr_t a);
    if (reset || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((bus.regWrite0 && bus.writeReg0 == a) || (bus.regWrite1 && bus.writeReg1 == a))
        && !(bus.resvValid && bus.resvReg == a)) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = bus.resvValid && bus.resvReg != 0 && m_pend[bus.resvReg];
      if (bus.regWrite0 && bus.writeReg0 != 0) begin
        m_regs[bus.writeReg0] = bus.writeData0;
        m_pend[bus.writeReg0] = 1'b0;
      end
      if (bus.regWrite1 && bus.writeReg1 != 0) begin
        m_regs[bus.writeReg1] = bus.writeData1;
        m_pend[bus.writeReg1] = 1'b0;
      end
      if (bus.resvValid && bus.resvReg != 0) m_pend[bus.resvReg] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.readReg1 = '0;
    bus.readReg2 = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.regWrite0 = 1'b1;
      bus.writeReg0 = reg_addr_t'($urandom_range(1, 31));
      bus.writeData0 = $urandom;
      bus.resvValid = 1'b1;
      bus.resvReg = reg_addr_t'($urandom_range(1, 31));
      bus.readReg1 = bus.writeReg0;
      bus.readReg2 = bus.resvReg;
      #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_rd1 got=%h exp=0", bus.readData1);
      end
      n_cmp++;
      if (bus.readPending1 !== 1'b0 || bus.readPending2 !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_pend got=%b%b exp=00", bus.readPending1, bus.readPending2);
      end
      tick();
    end
    reset = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      bus.readReg1 = reg_addr_t'(a);
      bus.readReg2 = reg_addr_t'(a);
      #1;
      n_cmp++;
      if (bus.readData1 !== 32'h0 || bus.readPending2 !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset r%0d got=%h/%b exp=0/0", a, bus.readData1, bus.readPending2);
      end
    end
    n_cmp++;
    if (bus.resvConflict !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_conflict got=%b exp=0", bus.resvConflict);
    end
  endtask

  task automatic test_write_basic();
    idle();
    bus.regWrite0 = 1'b1;
    bus.writeReg0 = 5'd5;
    bus.writeData0 = 32'hDEADBEEF;
    tick();
    idle();
    bus.readReg1 = 5'd5;
    bus.readReg2 = 5'd0;
    #1;
    n_cmp++;
    if (bus.readData1 !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL write_r5 got=%h exp=deadbeef", bus.readData1);
    end
    n_cmp++;
    if (bus.readData2 !== 32'h0) begin
      n_bad++;
      $display("FAIL read_r0 got=%h exp=0", bus.readData2);
    end
  endtask

  task automatic test_r0();
    idle();
    bus.regWrite0 = 1'b1;
    bus.regWrite1 = 1'b1;
    bus.writeData0 = 32'h1234;
    bus.writeData1 = 32'h1234;
    bus.readReg1 = 5'd0;
    #1;
    n_cmp++;
    if (bus.readData1 !== 32'h0) begin
      n_bad++;
      $display("FAIL r0_same_cycle got=%h exp=0", bus.readData1);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.readData1 !== 32'h0 || bus.readPending1 !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_write got=%h/%b exp=0/0", bus.readData1, bus.readPending1);
    end
  endtask

  task automatic test_same_reg();
    idle();
    bus.regWrite0 = 1'b1;
    bus.writeReg0 = 5'd7;
    bus.writeData0 = 32'h11;
    bus.regWrite1 = 1'b1;
    bus.writeReg1 = 5'd7;
    bus.writeData1 = 32'h22;
    bus.readReg1 = 5'd7;
    #1;
    n_cmp++;
`ifdef REGFILE_BYPASS_EN
    if (bus.readData1 !== 32'h22) begin
      n_bad++;
      $display("FAIL same_reg_bypass got=%h exp=22", bus.readData1);
    end
`else
    if (bus.readData1 !== 32'h0) begin
      n_bad++;
      $display("FAIL same_reg_prewrite got=%h exp=0", bus.readData1);
    end
`endif
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.readData1 !== 32'h22) begin
      n_bad++;
      $display("FAIL same_reg got=%h exp=22", bus.readData1);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.resvValid = 1'b1;
    bus.resvReg = 5'd9;
    bus.readReg1 = 5'd9;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.readPending1 !== 1'b1 || bus.resvConflict !== 1'b0) begin
      n_bad++;
      $display("FAIL resv_r9 got=%b/%b exp=1/0", bus.readPending1, bus.resvConflict);
    end
    bus.resvValid = 1'b1;
    bus.resvReg = 5'd9;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.resvConflict !== 1'b1 || bus.readPending1 !== 1'b1) begin
      n_bad++;
      $display("FAIL resv_conflict got=%b/%b exp=1/1", bus.resvConflict, bus.readPending1);
    end
    tick();
    n_cmp++;
    if (bus.resvConflict !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_pulse got=%b exp=0", bus.resvConflict);
    end
    bus.regWrite0 = 1'b1;
    bus.writeReg0 = 5'd9;
    bus.writeData0 = 32'h5;
    #1;
    n_cmp++;
`ifdef REGFILE_BYPASS_EN
    if (bus.readPending1 !== 1'b0) begin
      n_bad++;
      $display("FAIL release_bypass got=%b exp=0", bus.readPending1);
    end
`else
    if (bus.readPending1 !== 1'b1) begin
      n_bad++;
      $display("FAIL release_stored got=%b exp=1", bus.readPending1);
    end
`endif
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.readPending1 !== 1'b0 || bus.readData1 !== 32'h5) begin
      n_bad++;
      $display("FAIL release_r9 got=%b/%h exp=0/5", bus.readPending1, bus.readData1);
    end
  endtask

  task automatic test_resv_write();
    idle();
    bus.resvValid = 1'b1;
    bus.resvReg = 5'd3;
    bus.regWrite1 = 1'b1;
    bus.writeReg1 = 5'd3;
    bus.writeData1 = 32'h9;
    tick();
    idle();
    bus.readReg2 = 5'd3;
    #1;
    n_cmp++;
    if (bus.readData2 !== 32'h9 || bus.readPending2 !== 1'b1) begin
      n_bad++;
      $display("FAIL resv_write_r3 got=%h/%b exp=9/1", bus.readData2, bus.readPending2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.regWrite0 = 1'($urandom);
      bus.regWrite1 = 1'($urandom);
      bus.resvValid = ($urandom_range(0, 2) == 0);
      bus.writeReg0 = reg_addr_t'($urandom_range(0, 7));
      bus.writeReg1 = reg_addr_t'($urandom_range(0, 7));
      bus.resvReg = reg_addr_t'($urandom_range(0, 7));
      bus.writeData0 = $urandom;
      bus.writeData1 = $urandom;
      bus.readReg1 = reg_addr_t'($urandom_range(0, 7));
      bus.readReg2 = reg_addr_t'($urandom);
      #1;
      n_cmp++;
      if (bus.readData1 !== exp_data(bus.readReg1) || bus.readData2 !== exp_data(bus.readReg2)) begin
        n_bad++;
        $display("FAIL rand_data c=%0d got=%h/%h exp=%h/%h", c, bus.readData1, bus.readData2,
                 exp_data(bus.readReg1), exp_data(bus.readReg2));
      end
      n_cmp++;
      if (bus.readPending1 !== exp_pend(bus.readReg1) || bus.readPending2 !== exp_pend(bus.readReg2)) begin
        n_bad++;
        $display("FAIL rand_pend c=%0d got=%b%b exp=%b%b", c, bus.readPending1, bus.readPending2,
                 exp_pend(bus.readReg1), exp_pend(bus.readReg2));
      end
      n_cmp++;
      if (bus.resvConflict !== m_conf) begin
        n_bad++;
        $display("FAIL rand_conflict c=%0d got=%b exp=%b", c, bus.resvConflict, m_conf);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int a = 1; a < 32; a++) begin
      bus.regWrite0 = 1'b1;
      bus.writeReg0 = reg_addr_t'(a);
      bus.writeData0 = 32'h100 + 32'(a);
      tick();
    end
    idle();
    bus.resvValid = 1'b1;
    bus.resvReg = 5'd4;
    tick();
    idle();
    bus.readReg1 = 5'd4;
    #1;
    n_cmp++;
    if (bus.readPending1 !== 1'b1 || bus.readData1 !== 32'h104) begin
      n_bad++;
      $display("FAIL prefill_r4 got=%b/%h exp=1/104", bus.readPending1, bus.readData1);
    end
    reset = 1'b1;
    bus.regWrite0 = 1'b1;
    bus.writeReg0 = 5'd2;
    bus.writeData0 = 32'hFF;
    tick();
    reset = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      bus.readReg1 = reg_addr_t'(a);
      bus.readReg2 = reg_addr_t'(a);
      #1;
      n_cmp++;
      if (bus.readData2 !== 32'h0 || bus.readPending1 !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid r%0d got=%h/%b exp=0/0", a, bus.readData2, bus.readPending1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_conf = 1'b0;
    test_reset();
    test_write_basic();
    test_r0();
    test_same_reg();
    test_scoreboard();
    test_resv_write();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
